// File: rtl/serial_to_parallel_if.sv
// Handshake bundle for serial_to_parallel: serial bit input, word-length select,
// and the ready/valid word output with its overrun flag.
interface serial_to_parallel_if #(
  parameter int max_width = 16,
  parameter int wbits     = 5
);
  logic [wbits-1:0]     width;
  logic                 in_valid;
  logic                 in;
  logic                 out_ready;
  logic [max_width-1:0] data;
  logic                 out_valid;
  logic                 overrun;

  modport master (
    output width, in_valid, in, out_ready,
    input  data, out_valid, overrun
  );

  modport slave (
    input  width, in_valid, in, out_ready,
    output data, out_valid, overrun
  );
endinterface

// File: rtl/serial_to_parallel.sv
// Serial-to-parallel word assembler with a single-entry output register.
// Define SERIAL_TO_PARALLEL_MSB_FIRST_EN to place the first bit at the word MSB.
module serial_to_parallel #(
  parameter int max_width = 16,
  parameter int wbits     = 5
) (
  input logic                 clock,
  input logic                 reset,
  serial_to_parallel_if.slave bus
);
  localparam int CW = $clog2(max_width + 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t               state;
  logic [CW-1:0]        cnt;
  logic [CW-1:0]        eff_w;
  logic [max_width-1:0] shreg;
  logic [max_width-1:0] data_q;
  logic                 out_valid_q;
  logic                 overrun_q;

  logic [CW-1:0]        w_cur;
  logic [CW-1:0]        pos;
  logic                 last;
  logic [max_width-1:0] word_next;

  // Out-of-range word lengths (including zero) fall back to the full width.
  function automatic logic [CW-1:0] clamp_width(input logic [wbits-1:0] w);
    if (w == '0 || int'(w) > max_width) return CW'(max_width);
    return CW'(w);
  endfunction

  // The word length is latched on the first bit; later bits use the latched copy.
  always_comb begin
    w_cur = (state == IDLE) ? clamp_width(bus.width) : eff_w;
`ifdef SERIAL_TO_PARALLEL_MSB_FIRST_EN
    pos = w_cur - cnt - CW'(1);
`else
    pos = cnt;
`endif
    last      = (cnt == w_cur - CW'(1));
    word_next = shreg | (max_width'(bus.in) << pos);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      eff_w       <= '0;
      shreg       <= '0;
      data_q      <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      overrun_q <= 1'b0;
      if (out_valid_q && bus.out_ready) out_valid_q <= 1'b0;
      if (bus.in_valid) begin
        if (last) begin
          state <= IDLE;
          cnt   <= '0;
          shreg <= '0;
          // A finished word only lands if the register is empty or draining now.
          if (!out_valid_q || bus.out_ready) begin
            data_q      <= word_next;
            out_valid_q <= 1'b1;
          end else begin
            overrun_q <= 1'b1;
          end
        end else begin
          state <= SHIFT;
          cnt   <= cnt + CW'(1);
          shreg <= word_next;
          eff_w <= w_cur;
        end
      end
    end
  end

  assign bus.data      = data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.overrun   = overrun_q;
endmodule

// File: tb/tb_serial_to_parallel.sv
// Self-checking bench for serial_to_parallel: directed scenarios plus a randomized
// run, all compared against a word-level model built from a queue of received bits.
module tb_serial_to_parallel;
  localparam int MW = 16;
  localparam int WB = 5;

  logic clock = 1'b0;
  logic reset = 1'b1;

  serial_to_parallel_if #(.max_width(MW), .wbits(WB)) bus ();

  serial_to_parallel #(.max_width(MW), .wbits(WB)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit              m_bits[$];
  int              m_w;
  logic            m_valid;
  logic            m_ovr;
  logic [MW-1:0]   m_data;

  function automatic void model_reset();
    m_bits.delete();
    m_w     = 0;
    m_valid = 1'b0;
    m_ovr   = 1'b0;
    m_data  = '0;
  endfunction

  function automatic void model_edge();
    logic          valid_n;
    logic          ovr_n;
    logic [MW-1:0] data_n;
    logic [MW-1:0] word;
    int            w;
    valid_n = m_valid;
    data_n  = m_data;
    ovr_n   = 1'b0;
    if (m_valid && bus.out_ready) valid_n = 1'b0;
    if (bus.in_valid) begin
      if (m_bits.size() == 0) begin
        w = int'(bus.width);
        if (w == 0 || w > MW) w = MW;
        m_w = w;
      end
      m_bits.push_back(bus.in);
      if (m_bits.size() == m_w) begin
        word = '0;
        for (int k = 0; k < m_w; k++) begin
`ifdef SERIAL_TO_PARALLEL_MSB_FIRST_EN
          word[m_w-1-k] = m_bits[k];
`else
          word[k] = m_bits[k];
`endif
        end
        if (!m_valid || bus.out_ready) begin
          data_n  = word;
          valid_n = 1'b1;
        end else begin
          ovr_n = 1'b1;
        end
        m_bits.delete();
      end
    end
    m_valid = valid_n;
    m_data  = data_n;
    m_ovr   = ovr_n;
  endfunction

  // Advance one clock; model sees the pre-edge inputs, outputs sampled 1 time unit later.
  task automatic step();
    if (!reset) model_edge();
    @(posedge clock);
    #1;
  endtask

  task automatic send_bit(input bit b);
    bus.in_valid = 1'b1;
    bus.in       = b;
    step();
  endtask

  task automatic idle_cycle();
    bus.in_valid = 1'b0;
    bus.in       = 1'b0;
    step();
  endtask

  task automatic test_reset();
    bus.width = WB'(8); bus.in_valid = 1'b1; bus.in = 1'b1; bus.out_ready = 1'b0;
    reset = 1'b1;
    model_reset();
    repeat (3) step();
    checks++;
    if (bus.data !== '0) begin errors++; $display("FAIL reset_data got %h want 0", bus.data); end
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
    checks++;
    if (bus.overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b want 0", bus.overrun); end
    bus.in_valid = 1'b0;
    reset = 1'b0;
  endtask

  task automatic test_lsb_basic();
    bit pat[8] = '{1, 0, 1, 1, 0, 0, 0, 0};
    bus.width = WB'(8); bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send_bit(pat[i]);
      checks++;
      if ({bus.out_valid, bus.overrun, bus.data} !== {m_valid, m_ovr, m_data}) begin
        errors++;
        $display("FAIL basic_bit%0d got v=%b o=%b d=%h want v=%b o=%b d=%h", i,
                 bus.out_valid, bus.overrun, bus.data, m_valid, m_ovr, m_data);
      end
    end
    checks++;
`ifdef SERIAL_TO_PARALLEL_MSB_FIRST_EN
    if (bus.out_valid !== 1'b1 || bus.data !== 16'h00B0) begin
`else
    if (bus.out_valid !== 1'b1 || bus.data !== 16'h000D) begin
`endif
      errors++;
      $display("FAIL basic_word got v=%b d=%h", bus.out_valid, bus.data);
    end
    idle_cycle();
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL basic_consume got %b want 0", bus.out_valid); end
  endtask

  task automatic test_overrun();
    bit pat[4] = '{0, 1, 0, 1};
    bus.width = WB'(4); bus.out_ready = 1'b0;
    repeat (4) send_bit(1'b1);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.data !== 16'h000F) begin
      errors++; $display("FAIL ovr_first got v=%b d=%h want v=1 d=000f", bus.out_valid, bus.data);
    end
    for (int i = 0; i < 4; i++) send_bit(pat[i]);
    checks++;
    if (bus.overrun !== 1'b1 || bus.data !== 16'h000F || bus.out_valid !== 1'b1) begin
      errors++; $display("FAIL ovr_pulse got o=%b v=%b d=%h want o=1 v=1 d=000f", bus.overrun, bus.out_valid, bus.data);
    end
    idle_cycle();
    checks++;
    if (bus.overrun !== 1'b0) begin errors++; $display("FAIL ovr_one_cycle got %b want 0", bus.overrun); end
    bus.out_ready = 1'b1;
    idle_cycle();
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL ovr_drain got %b want 0", bus.out_valid); end
  endtask

  task automatic test_width_clamp();
    bit pat[3] = '{1, 0, 1};
    bus.width = WB'(0); bus.out_ready = 1'b1;
    send_bit(1'b1);
    bus.width = WB'(3);
    for (int i = 1; i < 16; i++) begin
      send_bit(1'b1);
      if (i == 14) begin
        checks++;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL clamp_early got %b want 0", bus.out_valid); end
      end
    end
    checks++;
    if (bus.out_valid !== 1'b1 || bus.data !== 16'hFFFF) begin
      errors++; $display("FAIL clamp_16 got v=%b d=%h want v=1 d=ffff", bus.out_valid, bus.data);
    end
    for (int i = 0; i < 3; i++) send_bit(pat[i]);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.data !== 16'h0005) begin
      errors++; $display("FAIL clamp_next3 got v=%b d=%h want v=1 d=0005", bus.out_valid, bus.data);
    end
    bus.width = WB'(20);
    for (int i = 0; i < 16; i++) send_bit(1'($urandom));
    checks++;
    if ({bus.out_valid, bus.overrun, bus.data} !== {m_valid, m_ovr, m_data}) begin
      errors++; $display("FAIL clamp_over got v=%b d=%h want v=%b d=%h", bus.out_valid, bus.data, m_valid, m_data);
    end
  endtask

  task automatic test_width_one();
    bit b;
    bus.width = WB'(1);
    for (int i = 0; i < 10; i++) begin
      bus.out_ready = (i < 5) ? 1'b1 : 1'($urandom);
      b = 1'($urandom);
      send_bit(b);
      checks++;
      if ({bus.out_valid, bus.overrun, bus.data} !== {m_valid, m_ovr, m_data}) begin
        errors++;
        $display("FAIL width1_%0d got v=%b o=%b d=%h want v=%b o=%b d=%h", i,
                 bus.out_valid, bus.overrun, bus.data, m_valid, m_ovr, m_data);
      end
      if (i < 5) begin
        checks++;
        if (bus.out_valid !== 1'b1 || bus.data !== {15'd0, b}) begin
          errors++; $display("FAIL width1_direct got v=%b d=%h want v=1 d=%h", bus.out_valid, bus.data, {15'd0, b});
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    bit pat[4] = '{1, 1, 0, 0};
`ifdef SERIAL_TO_PARALLEL_MSB_FIRST_EN
    bit a5[8] = '{1, 0, 1, 0, 0, 1, 0, 1};
`endif
    bus.width = WB'(4); bus.out_ready = 1'b1;
    for (int w = 0; w < 4; w++) begin
      for (int i = 0; i < 4; i++) send_bit(w == 0 ? pat[i] : 1'($urandom));
      checks++;
      if (bus.out_valid !== 1'b1 || bus.overrun !== 1'b0 || bus.data !== m_data) begin
        errors++; $display("FAIL b2b_word%0d got v=%b o=%b d=%h want v=1 o=0 d=%h", w,
                           bus.out_valid, bus.overrun, bus.data, m_data);
      end
      if (w == 0) begin
        checks++;
`ifdef SERIAL_TO_PARALLEL_MSB_FIRST_EN
        if (bus.data !== 16'h000C) begin errors++; $display("FAIL b2b_const got %h want 000c", bus.data); end
`else
        if (bus.data !== 16'h0003) begin errors++; $display("FAIL b2b_const got %h want 0003", bus.data); end
`endif
      end
    end
`ifdef SERIAL_TO_PARALLEL_MSB_FIRST_EN
    bus.width = WB'(8);
    for (int i = 0; i < 8; i++) send_bit(a5[i]);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.overrun !== 1'b0 || bus.data !== 16'h00A5) begin
      errors++; $display("FAIL msb_a5 got v=%b o=%b d=%h want v=1 o=0 d=00a5", bus.out_valid, bus.overrun, bus.data);
    end
`endif
  endtask

  task automatic test_async_reset();
    logic [7:0] a5 = 8'hA5;
    bus.width = WB'(8); bus.out_ready = 1'b0;
    idle_cycle();
    bus.out_ready = 1'b1;
    idle_cycle();
    bus.out_ready = 1'b0;
    send_bit(1'b1);
    repeat (7) send_bit(1'($urandom));
    repeat (5) send_bit(1'($urandom));
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    checks++;
    if (bus.data !== '0 || bus.out_valid !== 1'b0 || bus.overrun !== 1'b0) begin
      errors++; $display("FAIL async_reset got v=%b o=%b d=%h want all zero", bus.out_valid, bus.overrun, bus.data);
    end
    @(posedge clock); #1;
    bus.out_ready = 1'b1;
    repeat (2) send_bit(1'b1);
    reset = 1'b0;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
`ifdef SERIAL_TO_PARALLEL_MSB_FIRST_EN
      send_bit(a5[7-i]);
`else
      send_bit(a5[i]);
`endif
    end
    checks++;
    if (bus.out_valid !== 1'b1 || bus.data !== 16'h00A5) begin
      errors++; $display("FAIL after_reset got v=%b d=%h want v=1 d=00a5", bus.out_valid, bus.data);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 15) == 0) bus.width = WB'($urandom);
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.in        = 1'($urandom);
      bus.out_ready = ($urandom_range(0, 2) == 0);
      step();
      checks++;
      if ({bus.out_valid, bus.overrun, bus.data} !== {m_valid, m_ovr, m_data}) begin
        errors++;
        $display("FAIL random_%0d got v=%b o=%b d=%h want v=%b o=%b d=%h", i,
                 bus.out_valid, bus.overrun, bus.data, m_valid, m_ovr, m_data);
      end
    end
  endtask

  initial begin
    bus.width = '0; bus.in_valid = 1'b0; bus.in = 1'b0; bus.out_ready = 1'b0;
    model_reset();
    test_reset();
    test_lsb_basic();
    test_overrun();
    test_width_clamp();
    test_width_one();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
